// File: rtl/czono_plus_engine.sv
// Constrained-zonotope Minkowski sum engine: OUT.c = Z.c +/- W.c, LANES elements per beat,
// plus OUT dimensions and the column/row offsets used by the G/A/b concatenation writer.
module czono_plus_engine #(
  parameter int NMAX       = 512,
  parameter int NGMAX      = 512,
  parameter int NCMAX      = 512,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int SAT        = 1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       start_i,
  input  logic                       mode_i,
  input  logic [$clog2(NMAX):0]      z_n_i,
  input  logic [$clog2(NMAX):0]      w_n_i,
  input  logic [$clog2(NGMAX):0]     z_ng_i,
  input  logic [$clog2(NGMAX):0]     w_ng_i,
  input  logic [$clog2(NCMAX):0]     z_nc_i,
  input  logic [$clog2(NCMAX):0]     w_nc_i,
  input  logic [NMAX*DATA_WIDTH-1:0] z_c_i,
  input  logic [NMAX*DATA_WIDTH-1:0] w_c_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [2:0]                 err_o,
  output logic                       ovf_o,
  output logic [$clog2(NMAX):0]      out_n_o,
  output logic [$clog2(NGMAX):0]     out_ng_o,
  output logic [$clog2(NCMAX):0]     out_nc_o,
  output logic [$clog2(NGMAX):0]     col_off_o,
  output logic [$clog2(NCMAX):0]     row_off_o,
  output logic [NMAX*DATA_WIDTH-1:0] out_c_o
);
  localparam int DW     = DATA_WIDTH;
  localparam int NW     = $clog2(NMAX) + 1;
  localparam int GW     = $clog2(NGMAX) + 1;
  localparam int CW     = $clog2(NCMAX) + 1;
  localparam int GW1    = GW + 1;
  localparam int CW1    = CW + 1;
  localparam int NBEATS = (NMAX + LANES - 1) / LANES;
  localparam int BW     = $clog2(NBEATS + 1);
  localparam int IW     = $clog2(NMAX + LANES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t                 state_r, state_s;
  logic                   mode_r;
  logic [NW-1:0]          z_n_r, w_n_r;
  logic [GW-1:0]          z_ng_r, w_ng_r;
  logic [CW-1:0]          z_nc_r, w_nc_r;
  logic [BW-1:0]          beat_r;
  logic                   busy_r, done_r, ovf_r;
  logic [2:0]             err_r, err_s;
  logic [NW-1:0]          out_n_r;
  logic [GW-1:0]          out_ng_r, col_off_r;
  logic [CW-1:0]          out_nc_r, row_off_r;
  logic [NMAX*DW-1:0]     out_c_r;
  logic [GW:0]            ng_sum_s;
  logic [CW:0]            nc_sum_s;
  logic [IW-1:0]          base_s;
  logic                   last_beat_s;
  logic [IW-1:0]          lane_idx_s [LANES];
  logic [DW-1:0]          lane_res_s [LANES];
  logic [LANES-1:0]       lane_ovf_s, lane_wr_s;

  // Extended-precision add/sub returning {overflow, result}; clamps when SAT is set.
  function automatic logic [DW:0] lane_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic sub);
    logic [DW:0]   s;
    logic          ov;
    logic [DW-1:0] r;
    if (sub) s = {a[DW-1], a} - {b[DW-1], b};
    else     s = {a[DW-1], a} + {b[DW-1], b};
    ov = s[DW] ^ s[DW-1];
    if (ov && (SAT != 0)) r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else                  r = s[DW-1:0];
    return {ov, r};
  endfunction

  // Dimension checks on latched operands; sums carry an extra bit so the bound test cannot wrap.
  always_comb begin
    ng_sum_s = {1'b0, z_ng_r} + {1'b0, w_ng_r};
    nc_sum_s = {1'b0, z_nc_r} + {1'b0, w_nc_r};
    err_s[0] = (z_n_r != w_n_r);
    err_s[1] = (z_n_r > NW'(NMAX)) || (w_n_r > NW'(NMAX));
    err_s[2] = (ng_sum_s > GW1'(NGMAX)) || (nc_sum_s > CW1'(NCMAX));
  end

  // Per-lane element selection and arithmetic for the current beat.
  always_comb begin
    base_s      = IW'(beat_r) * IW'(LANES);
    last_beat_s = ((base_s + IW'(LANES)) >= IW'(z_n_r));
    for (int l = 0; l < LANES; l++) begin
      lane_idx_s[l] = base_s + IW'(l);
      lane_wr_s[l]  = 1'b0;
      lane_ovf_s[l] = 1'b0;
      lane_res_s[l] = {DW{1'b0}};
      if (lane_idx_s[l] < IW'(NMAX)) begin
        lane_wr_s[l] = 1'b1;
        if (lane_idx_s[l] < IW'(z_n_r)) begin
          {lane_ovf_s[l], lane_res_s[l]} = lane_op(z_c_i[int'(lane_idx_s[l])*DW +: DW],
                                                   w_c_i[int'(lane_idx_s[l])*DW +: DW], mode_r);
        end else begin
          lane_res_s[l] = {DW{1'b0}};
        end
      end else begin
        lane_wr_s[l] = 1'b0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) state_s = S_CHECK;
        else         state_s = S_IDLE;
      end
      S_CHECK: begin
        if ((|err_s) || (z_n_r == {NW{1'b0}})) state_s = S_DONE;
        else                                   state_s = S_RUN;
      end
      S_RUN: begin
        if (last_beat_s) state_s = S_DONE;
        else             state_s = S_RUN;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_r <= S_IDLE;
    else         state_r <= state_s;
  end

  // Operand latching, handshake, error/overflow flags and OUT dimensions.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_r    <= 1'b0;
      z_n_r     <= {NW{1'b0}};
      w_n_r     <= {NW{1'b0}};
      z_ng_r    <= {GW{1'b0}};
      w_ng_r    <= {GW{1'b0}};
      z_nc_r    <= {CW{1'b0}};
      w_nc_r    <= {CW{1'b0}};
      beat_r    <= {BW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      err_r     <= 3'b000;
      out_n_r   <= {NW{1'b0}};
      out_ng_r  <= {GW{1'b0}};
      out_nc_r  <= {CW{1'b0}};
      col_off_r <= {GW{1'b0}};
      row_off_r <= {CW{1'b0}};
    end else begin
      done_r <= (state_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            mode_r <= mode_i;
            z_n_r  <= z_n_i;
            w_n_r  <= w_n_i;
            z_ng_r <= z_ng_i;
            w_ng_r <= w_ng_i;
            z_nc_r <= z_nc_i;
            w_nc_r <= w_nc_i;
            busy_r <= 1'b1;
            ovf_r  <= 1'b0;
            err_r  <= 3'b000;
          end
        end
        S_CHECK: begin
          err_r  <= err_s;
          beat_r <= {BW{1'b0}};
          if (|err_s) begin
            out_n_r   <= {NW{1'b0}};
            out_ng_r  <= {GW{1'b0}};
            out_nc_r  <= {CW{1'b0}};
            col_off_r <= {GW{1'b0}};
            row_off_r <= {CW{1'b0}};
          end else begin
            out_n_r   <= z_n_r;
            out_ng_r  <= ng_sum_s[GW-1:0];
            out_nc_r  <= nc_sum_s[CW-1:0];
            col_off_r <= z_ng_r;
            row_off_r <= z_nc_r;
          end
        end
        S_RUN: begin
          beat_r <= beat_r + BW'(1'b1);
          ovf_r  <= ovf_r | (|lane_ovf_s);
        end
        S_DONE:  busy_r <= 1'b0;
        default: busy_r <= 1'b0;
      endcase
      if (state_s == S_DONE) busy_r <= 1'b0;
    end
  end

  // Center datapath: cleared at accept, one LANES-wide slice written per RUN beat.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_c_r <= {(NMAX*DW){1'b0}};
    end else if ((state_r == S_IDLE) && start_i) begin
      out_c_r <= {(NMAX*DW){1'b0}};
    end else if (state_r == S_RUN) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_wr_s[l]) out_c_r[int'(lane_idx_s[l])*DW +: DW] <= lane_res_s[l];
      end
    end
  end

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign err_o     = err_r;
  assign ovf_o     = ovf_r;
  assign out_n_o   = out_n_r;
  assign out_ng_o  = out_ng_r;
  assign out_nc_o  = out_nc_r;
  assign col_off_o = col_off_r;
  assign row_off_o = row_off_r;
  assign out_c_o   = out_c_r;

endmodule

// File: tb/tb_czono_plus_engine.sv
// Scoreboard bench for czono_plus_engine: two instances (LANES=2/SAT=1 and LANES=3/SAT=0)
// share stimulus; an arithmetic reference model predicts results and completion cycles.
module tb_czono_plus_engine;
  localparam int NMAX = 8, NGMAX = 512, NCMAX = 512, DW = 32;
  localparam int CWD = NMAX * DW;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, mode = 1'b0;
  logic [3:0] z_n = 4'd0, w_n = 4'd0;
  logic [9:0] z_ng = 10'd0, w_ng = 10'd0, z_nc = 10'd0, w_nc = 10'd0;
  logic [CWD-1:0] z_c = '0, w_c = '0;

  logic a_busy, a_done, a_ovf, b_busy, b_done, b_ovf;
  logic [2:0] a_err, b_err;
  logic [3:0] a_out_n, b_out_n;
  logic [9:0] a_out_ng, a_out_nc, a_col, a_row, b_out_ng, b_out_nc, b_col, b_row;
  logic [CWD-1:0] a_out_c, b_out_c;

  typedef struct {
    logic [CWD-1:0] c;
    logic [3:0]     n;
    logic [9:0]     ng, nc, col, row;
    logic [2:0]     err;
    logic           ovf;
    int             done_cyc;
  } exp_t;

  exp_t q_a[$], q_b[$];
  exp_t e_a, e_b;
  int checks = 0, errors = 0, cyc = 0;

  czono_plus_engine #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW),
                      .LANES(2), .SAT(1)) u_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .mode_i(mode),
    .z_n_i(z_n), .w_n_i(w_n), .z_ng_i(z_ng), .w_ng_i(w_ng), .z_nc_i(z_nc), .w_nc_i(w_nc),
    .z_c_i(z_c), .w_c_i(w_c), .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .ovf_o(a_ovf),
    .out_n_o(a_out_n), .out_ng_o(a_out_ng), .out_nc_o(a_out_nc), .col_off_o(a_col),
    .row_off_o(a_row), .out_c_o(a_out_c));

  czono_plus_engine #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW),
                      .LANES(3), .SAT(0)) u_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .mode_i(mode),
    .z_n_i(z_n), .w_n_i(w_n), .z_ng_i(z_ng), .w_ng_i(w_ng), .z_nc_i(z_nc), .w_nc_i(w_nc),
    .z_c_i(z_c), .w_c_i(w_c), .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .ovf_o(b_ovf),
    .out_n_o(b_out_n), .out_ng_o(b_out_ng), .out_nc_o(b_out_nc), .col_off_o(b_col),
    .row_off_o(b_row), .out_c_o(b_out_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string what, input logic [CWD-1:0] act, input logic [CWD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  // Reference: elementwise signed arithmetic at 64 bits, then clamp or truncate.
  function automatic exp_t model(input int lanes, input bit sat, input int acc);
    exp_t e;
    longint s;
    int beats;
    logic [31:0] zv, wv, r;
    e.c = '0; e.ovf = 1'b0; e.err = 3'b000;
    e.n = 4'd0; e.ng = 10'd0; e.nc = 10'd0; e.col = 10'd0; e.row = 10'd0;
    e.err[0] = (z_n != w_n);
    e.err[1] = (int'(z_n) > NMAX) || (int'(w_n) > NMAX);
    e.err[2] = (int'(z_ng) + int'(w_ng) > NGMAX) || (int'(z_nc) + int'(w_nc) > NCMAX);
    beats = 0;
    if (e.err == 3'b000) begin
      e.n = z_n; e.ng = z_ng + w_ng; e.nc = z_nc + w_nc; e.col = z_ng; e.row = z_nc;
      beats = (int'(z_n) + lanes - 1) / lanes;
      for (int i = 0; i < int'(z_n); i++) begin
        zv = z_c[i*DW +: DW];
        wv = w_c[i*DW +: DW];
        if (mode) s = longint'($signed(zv)) - longint'($signed(wv));
        else      s = longint'($signed(zv)) + longint'($signed(wv));
        if (s > 64'sd2147483647) begin
          e.ovf = 1'b1; r = sat ? 32'h7fffffff : 32'(s);
        end else if (s < -64'sd2147483648) begin
          e.ovf = 1'b1; r = sat ? 32'h80000000 : 32'(s);
        end else begin
          r = 32'(s);
        end
        e.c[i*DW +: DW] = r;
      end
    end
    e.done_cyc = acc + 1 + beats;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input logic [CWD-1:0] c, input logic [3:0] n,
                     input logic [9:0] ng, input logic [9:0] nc, input logic [9:0] col,
                     input logic [9:0] row, input logic [2:0] err, input logic ovf, input logic busy);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_out_c"}, c, e.c);
    chk({tag, "_dims"}, {n, ng, nc, col, row}, {e.n, e.ng, e.nc, e.col, e.row});
    chk({tag, "_err"}, err, e.err);
    chk({tag, "_ovf"}, ovf, e.ovf);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  // Monitors: every done_o pulse must match the oldest prediction for that instance.
  always @(negedge clk) begin
    if (rstn && a_done) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL A_unexpected_done: got done_o=1 at cycle %0d expected no completion", cyc);
      end else begin
        e_a = q_a.pop_front();
        cmp("A", e_a, a_out_c, a_out_n, a_out_ng, a_out_nc, a_col, a_row, a_err, a_ovf, a_busy);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && b_done) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL B_unexpected_done: got done_o=1 at cycle %0d expected no completion", cyc);
      end else begin
        e_b = q_b.pop_front();
        cmp("B", e_b, b_out_c, b_out_n, b_out_ng, b_out_nc, b_col, b_row, b_err, b_ovf, b_busy);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_A_ctrl"}, {a_busy, a_done, a_err, a_ovf, a_out_n, a_out_ng, a_out_nc, a_col, a_row}, '0);
    chk({tag, "_A_out_c"}, a_out_c, '0);
    chk({tag, "_B_ctrl"}, {b_busy, b_done, b_err, b_ovf, b_out_n, b_out_ng, b_out_nc, b_col, b_row}, '0);
    chk({tag, "_B_out_c"}, b_out_c, '0);
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0:       rv = 32'h7fffffff;
      1:       rv = 32'h80000000;
      2:       rv = 32'($urandom_range(0, 20)) - 32'd10;
      default: rv = $urandom;
    endcase
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < NMAX; i++) begin
      z_c[i*DW +: DW] = rv();
      w_c[i*DW +: DW] = rv();
    end
  endtask

  task automatic set_op(input logic m, input int zn, input int wn, input int zng, input int wng,
                        input int znc, input int wnc);
    mode = m; z_n = 4'(zn); w_n = 4'(wn);
    z_ng = 10'(zng); w_ng = 10'(wng); z_nc = 10'(znc); w_nc = 10'(wnc);
  endtask

  task automatic set_el(input int i, input int zv, input int wv);
    z_c[i*DW +: DW] = 32'(zv);
    w_c[i*DW +: DW] = 32'(wv);
  endtask

  // Raise start for 'hold' edges; predict every accept each instance makes, then wait it out.
  task automatic issue(input int hold);
    int acc, t, last_a, last_b;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    acc = cyc + 1;
    t = acc; last_a = acc;
    while (t <= acc + hold - 1) begin
      e = model(2, 1'b1, t); q_a.push_back(e); last_a = e.done_cyc; t = e.done_cyc + 2;
    end
    t = acc; last_b = acc;
    while (t <= acc + hold - 1) begin
      e = model(3, 1'b0, t); q_b.push_back(e); last_b = e.done_cyc; t = e.done_cyc + 2;
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (cyc < ((last_a > last_b) ? last_a : last_b) + 2) @(negedge clk);
    chk("A_pending_done", q_a.size(), 0);
    chk("B_pending_done", q_b.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    fill_rand(); set_op(1'b0, 4, 4, 3, 2, 1, 2);
    set_el(0, 1, 10); set_el(1, 2, 20); set_el(2, 3, 30); set_el(3, 4, 40);
    issue(1);

    fill_rand(); set_op(1'b1, 3, 3, 3, 2, 1, 2);
    set_el(0, 5, 7); set_el(1, 0, -3); set_el(2, -1, -1);
    issue(1);

    fill_rand(); set_op(1'b0, 3, 4, 3, 2, 1, 2); issue(1);
    fill_rand(); set_op(1'b0, 4, 4, 300, 300, 1, 2); issue(1);
    fill_rand(); set_op(1'b0, 9, 9, 1, 1, 1, 1); issue(1);

    fill_rand(); set_op(1'b0, 1, 1, 1, 1, 1, 1);
    set_el(0, 32'h7fffffff, 1);
    issue(1);

    fill_rand(); set_op(1'b0, 0, 0, 4, 4, 4, 4); issue(1);
    fill_rand(); set_op(1'b0, 8, 8, 5, 6, 7, 8); issue(10);

    fill_rand(); set_op(1'b0, 8, 8, 1, 1, 1, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rstn = 1'b0;
    #1;
    chk_zero("mid_run_reset");
    @(negedge clk); rstn = 1'b1;
    repeat (12) @(negedge clk);
    fill_rand(); set_op(1'b1, 7, 7, 10, 20, 30, 40); issue(1);

    for (int k = 0; k < 40; k++) begin
      fill_rand();
      set_op(1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 300), $urandom_range(0, 300),
             $urandom_range(0, 300), $urandom_range(0, 300));
      z_n = 4'($urandom_range(0, 8));
      w_n = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : z_n;
      issue(($urandom_range(0, 4) == 0) ? 6 : 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
